cavlc_seq_ctrl: RTL and testbench

CAVLC_SEQ_CTRL -- requirements
Module: cavlc_seq_ctrl

---
 rtl/cavlc_seq_ctrl.sv | 175 +++++++++++++++++
 tb/tb_cavlc_seq_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cavlc_seq_ctrl.sv
// Sequencer for the CAVLC encoder: runs preprocessing and the four coding stages of one
// 4x4 block, and merges the stage bitstreams. Optional stage watchdog: CAVLC_SEQ_WDOG_EN.
module cavlc_seq_ctrl #(
    parameter int NZQ_WIDTH   = 5,
    parameter int WDOG_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 blk_start,
    output logic                 counters_en,
    input  logic                 preprocessingEndFlag,
    input  logic [NZQ_WIDTH-1:0] NZQ_num,
    input  logic [NZQ_WIDTH-1:0] totalZerosNum,
    output logic                 start_coeff_token,
    output logic                 start_levels,
    output logic                 start_total_zeros,
    output logic                 start_run_before,
    input  logic                 finish_coeff_token,
    input  logic                 finish_levels,
    input  logic                 finish_total_zeros,
    input  logic                 finish_run_before,
    input  logic                 ct_push,
    input  logic                 ct_data,
    input  logic                 lv_push,
    input  logic                 lv_data,
    input  logic                 tz_push,
    input  logic                 tz_data,
    input  logic                 rb_push,
    input  logic                 rb_data,
    output logic                 fifo_push,
    output logic                 fifo_data,
    output logic                 busy,
    output logic                 done
`ifdef CAVLC_SEQ_WDOG_EN
    ,
    output logic                 wdog_err
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        PREPROC,
        COEFF_TOKEN,
        LEVELS,
        TOTAL_ZEROS,
        RUN_BEFORE,
        DONE
    } state_t;

    state_t                 state_reg, state_next;
    logic                   first_reg;
    logic [NZQ_WIDTH-1:0]   nzq_reg;
    logic [NZQ_WIDTH-1:0]   tz_reg;
    logic                   fifo_push_reg, fifo_data_reg;
    logic                   own_push, own_data;
    logic                   latch_counts;

`ifdef CAVLC_SEQ_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    logic [WDOG_W-1:0]      wdog_cnt_reg;
    logic                   wdog_err_reg;
    logic                   wdog_fire;
    logic                   in_stage;
`else
    // Timeout is not built in this configuration; a nonsensical value elaborates to nothing.
    if (WDOG_CYCLES < 1) begin : g_wdog_unused
    end
`endif

    always_comb begin
        state_next   = state_reg;
        own_push     = 1'b0;
        own_data     = 1'b0;
        latch_counts = 1'b0;
        // A stage's finish counts only after its start cycle has passed.
        case (state_reg)
            IDLE: begin
                if (blk_start) state_next = PREPROC;
            end
            PREPROC: begin
                if (preprocessingEndFlag) begin
                    latch_counts = 1'b1;
                    state_next   = COEFF_TOKEN;
                end
            end
            COEFF_TOKEN: begin
                own_push = ct_push;
                own_data = ct_data;
                if (finish_coeff_token && !first_reg)
                    state_next = (nzq_reg == '0) ? DONE : LEVELS;
            end
            LEVELS: begin
                own_push = lv_push;
                own_data = lv_data;
                if (finish_levels && !first_reg)
                    state_next = (nzq_reg == NZQ_WIDTH'(16)) ? DONE : TOTAL_ZEROS;
            end
            TOTAL_ZEROS: begin
                own_push = tz_push;
                own_data = tz_data;
                if (finish_total_zeros && !first_reg)
                    state_next = (tz_reg != '0 && nzq_reg > NZQ_WIDTH'(1)) ? RUN_BEFORE : DONE;
            end
            RUN_BEFORE: begin
                own_push = rb_push;
                own_data = rb_data;
                if (finish_run_before && !first_reg) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

`ifdef CAVLC_SEQ_WDOG_EN
        in_stage  = (state_reg != IDLE) && (state_reg != DONE);
        wdog_fire = 1'b0;
        if (in_stage && state_next == state_reg &&
            wdog_cnt_reg == WDOG_W'(WDOG_CYCLES - 1)) begin
            wdog_fire  = 1'b1;
            state_next = DONE;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            first_reg     <= 1'b0;
            nzq_reg       <= '0;
            tz_reg        <= '0;
            fifo_push_reg <= 1'b0;
            fifo_data_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            first_reg     <= (state_next != state_reg);
            fifo_push_reg <= own_push;
            fifo_data_reg <= own_data;
            if (latch_counts) begin
                nzq_reg <= NZQ_num;
                tz_reg  <= totalZerosNum;
            end
        end
    end

`ifdef CAVLC_SEQ_WDOG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt_reg <= '0;
            wdog_err_reg <= 1'b0;
        end else begin
            if (state_next != state_reg || state_reg == IDLE)
                wdog_cnt_reg <= '0;
            else
                wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
            if (wdog_fire) wdog_err_reg <= 1'b1;
        end
    end

    assign wdog_err = wdog_err_reg;
`endif

    assign counters_en       = (state_reg == PREPROC);
    assign start_coeff_token = (state_reg == COEFF_TOKEN) && first_reg;
    assign start_levels      = (state_reg == LEVELS)      && first_reg;
    assign start_total_zeros = (state_reg == TOTAL_ZEROS) && first_reg;
    assign start_run_before  = (state_reg == RUN_BEFORE)  && first_reg;
    assign busy              = (state_reg != IDLE);
    assign done              = (state_reg == DONE);
    assign fifo_push         = fifo_push_reg;
    assign fifo_data         = fifo_data_reg;

endmodule

// File: tb/tb_cavlc_seq_ctrl.sv
// Randomized bench for cavlc_seq_ctrl: stage order and merged bitstream are predicted from
// the block's counts; stage responders are emulated in lockstep with the DUT.
module tb_cavlc_seq_ctrl;

`ifdef CAVLC_SEQ_WDOG_EN
    localparam int WDOG = 8;
`else
    localparam int WDOG = 255;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       blk_start = 1'b0;
    logic       pef = 1'b0;
    logic [4:0] nzq_in = '0;
    logic [4:0] tz_in = '0;
    logic [3:0] fin_v = '0;
    logic [3:0] push_v = '0;
    logic [3:0] data_v = '0;
    logic       counters_en, fifo_push, fifo_data, busy, done;
    logic       s_ct, s_lv, s_tz, s_rb;
    wire  [3:0] start_v = {s_rb, s_tz, s_lv, s_ct};
`ifdef CAVLC_SEQ_WDOG_EN
    logic       wdog_err;
    logic       exp_wdog = 1'b0;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    logic exp_push_pend = 1'b0;
    logic exp_data_pend = 1'b0;

    always #5 clk = ~clk;

    cavlc_seq_ctrl #(.NZQ_WIDTH(5), .WDOG_CYCLES(WDOG)) dut (
        .clk(clk), .rst(rst), .blk_start(blk_start), .counters_en(counters_en),
        .preprocessingEndFlag(pef), .NZQ_num(nzq_in), .totalZerosNum(tz_in),
        .start_coeff_token(s_ct), .start_levels(s_lv),
        .start_total_zeros(s_tz), .start_run_before(s_rb),
        .finish_coeff_token(fin_v[0]), .finish_levels(fin_v[1]),
        .finish_total_zeros(fin_v[2]), .finish_run_before(fin_v[3]),
        .ct_push(push_v[0]), .ct_data(data_v[0]),
        .lv_push(push_v[1]), .lv_data(data_v[1]),
        .tz_push(push_v[2]), .tz_data(data_v[2]),
        .rb_push(push_v[3]), .rb_data(data_v[3]),
        .fifo_push(fifo_push), .fifo_data(fifo_data),
        .busy(busy), .done(done)
`ifdef CAVLC_SEQ_WDOG_EN
        , .wdog_err(wdog_err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to the next falling edge and verify the bit forwarded from last cycle.
    task automatic tick();
        @(negedge clk);
        check("fifo_push", {31'b0, fifo_push}, {31'b0, exp_push_pend});
        if (exp_push_pend) check("fifo_data", {31'b0, fifo_data}, {31'b0, exp_data_pend});
    endtask

    // Random pushes on every stream; only the active stage's are expected downstream.
    task automatic drive(input int active, input logic fin);
        logic [3:0] p, d;
        p = 4'($urandom);
        d = 4'($urandom);
        for (int i = 0; i < 4; i++)
            fin_v[i] = (i == active) ? fin : ($urandom_range(0, 7) == 0);
        push_v = p;
        data_v = d;
        exp_push_pend = 1'b0;
        exp_data_pend = 1'b0;
        if (active >= 0) begin
            exp_push_pend = p[active];
            exp_data_pend = d[active];
        end
    endtask

    task automatic check_ctl(input string tag, input logic [3:0] st, input logic b,
                             input logic dn, input logic ce);
        check({tag, "_start"}, {28'b0, start_v}, {28'b0, st});
        check({tag, "_busy"}, {31'b0, busy}, {31'b0, b});
        check({tag, "_done"}, {31'b0, done}, {31'b0, dn});
        check({tag, "_cnten"}, {31'b0, counters_en}, {31'b0, ce});
`ifdef CAVLC_SEQ_WDOG_EN
        check({tag, "_wdog"}, {31'b0, wdog_err}, {31'b0, exp_wdog});
`endif
    endtask

    task automatic check_zero(input string tag);
`ifdef CAVLC_SEQ_WDOG_EN
        exp_wdog = 1'b0;
`endif
        check_ctl(tag, 4'b0, 1'b0, 1'b0, 1'b0);
        check({tag, "_fpush"}, {31'b0, fifo_push}, 32'd0);
        check({tag, "_fdata"}, {31'b0, fifo_data}, 32'd0);
    endtask

    // One block; abort_stage resets the DUT inside that stage, hang_stage never finishes it.
    task automatic run_block(input int nzq, input int tz, input int abort_stage,
                             input int hang_stage);
        int stages[$];
        int lat;
        logic fin;
        stages = {0};
        if (nzq > 0) begin
            stages.push_back(1);
            if (nzq < 16) stages.push_back(2);
            if (tz > 0 && nzq > 1) stages.push_back(3);
        end

        blk_start = 1'b1;
        drive(-1, 1'b0);
        tick();
        check_ctl("preproc", 4'b0, 1'b1, 1'b0, 1'b1);
        repeat ($urandom_range(0, 2)) begin
            blk_start = 1'($urandom_range(0, 1));
            drive(-1, 1'b0);
            tick();
            check_ctl("preproc_wait", 4'b0, 1'b1, 1'b0, 1'b1);
        end
        blk_start = 1'b0;
        pef = 1'b1;
        nzq_in = 5'(nzq);
        tz_in = 5'(tz);
        drive(-1, 1'b0);
        tick();
        pef = 1'b0;
        nzq_in = 5'($urandom);
        tz_in = 5'($urandom);

        foreach (stages[k]) begin
            lat = (stages[k] == hang_stage) ? WDOG : $urandom_range(1, 4);
            for (int c = 0; c <= lat; c++) begin
                if (stages[k] == hang_stage && c == lat) break;
                if (c == 0) check_ctl("stage_first", 4'(1 << stages[k]), 1'b1, 1'b0, 1'b0);
                else        check_ctl("stage_wait", 4'b0, 1'b1, 1'b0, 1'b0);
                if (stages[k] == abort_stage && c == 1) begin
                    drive(stages[k], 1'b0);
                    rst = 1'b1;
                    #1;
                    check_zero("abort_async");
                    exp_push_pend = 1'b0;
                    @(negedge clk);
                    check_zero("abort_held");
                    rst = 1'b0;
                    repeat (3) begin
                        drive(-1, 1'b0);
                        tick();
                        check_ctl("after_abort", 4'b0, 1'b0, 1'b0, 1'b0);
                    end
                    return;
                end
                fin = (stages[k] != hang_stage) &&
                      ((c == lat) || (c == 0 && $urandom_range(0, 2) == 0));
                blk_start = ($urandom_range(0, 3) == 0);
                drive(stages[k], fin);
                tick();
            end
            if (stages[k] == hang_stage) break;
        end

        blk_start = 1'b0;
`ifdef CAVLC_SEQ_WDOG_EN
        if (hang_stage >= 0) exp_wdog = 1'b1;
`endif
        check_ctl("done", 4'b0, 1'b1, 1'b1, 1'b0);
        drive(-1, 1'b0);
        tick();
        check_ctl("idle", 4'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int nzq, tz;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        drive(-1, 1'b0);
        tick();
        check_ctl("idle0", 4'b0, 1'b0, 1'b0, 1'b0);

        run_block(0, 0, -1, -1);
        run_block(3, 2, -1, -1);
        run_block(16, 0, -1, -1);
        run_block(1, 5, -1, -1);
        run_block(3, 2, 1, -1);
        run_block(3, 2, -1, -1);
        for (int n = 0; n < 40; n++) begin
            nzq = $urandom_range(0, 16);
            tz = (nzq == 0) ? 0 : $urandom_range(0, 16 - nzq);
            run_block(nzq, tz, -1, -1);
        end
`ifdef CAVLC_SEQ_WDOG_EN
        run_block(3, 2, -1, 1);
        run_block(5, 1, -1, -1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
